// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch controller with 2-entry instruction buffer
//
// Fetches one instruction per divided imem_clk period. imem_clk is sampled as
// data through a SYNC_STAGES-deep synchronizer. A rise event issues the fetch
// (imem_addr/imem_en registered). A fall event captures imem_rdata into a
// 2-entry FIFO of {pc, instr}.
//
// Optional feature: define IMEM_FETCH_CNT_EN to add the 16-bit fetch_count output.
//
// Ports:
//   clk          system clock; every flop uses its rising edge
//   reset        asynchronous active-low reset
//   imem_clk     divided imem clock level, sampled as data
//   pc_load      redirect strobe: flushes the buffer, aborts the access, loads pc_in
//   pc_in        redirect target
//   imem_rdata   instruction data returned by memory
//   imem_addr    fetch address
//   imem_en      fetch request, held for the whole access
//   instr_out    head-of-buffer instruction
//   instr_pc     PC of instr_out
//   instr_valid  buffer non-empty
//   out_ready    consumer accept; pop on instr_valid & out_ready
//   stall        buffer occupancy plus in-flight fetch equals 2
//   fetch_count  (IMEM_FETCH_CNT_EN only) number of pushes, wraps at 16 bits
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_clk,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        out_ready,
  output logic        stall
`ifdef IMEM_FETCH_CNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_evt;
  logic                   fall_evt;
  logic [31:0]            pc_q;
  logic [63:0]            fifo_mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count_q;
  logic                   do_issue;
  logic                   do_push;
  logic                   do_pop;

  // sync_q[0] is the first stage; edges are taken from the two oldest bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], imem_clk};
    end
  end

  assign rise_evt = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign fall_evt = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect has priority over every event. A rise seen while the buffer
  // is full is simply dropped; the next rise retries.
  always_comb begin
    state_d  = state_q;
    do_issue = 1'b0;
    do_push  = 1'b0;
    if (pc_load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_evt && (count_q < 2'd2)) begin
            state_d  = BUSY;
            do_issue = 1'b1;
          end
        end
        BUSY: begin
          if (fall_evt) begin
            state_d = IDLE;
            do_push = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Issue only happens with at most one entry held, so a push never meets a full buffer.
  assign do_pop = instr_valid & out_ready & ~pc_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      imem_addr   <= '0;
      imem_en     <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count_q     <= '0;
    end else if (pc_load) begin
      pc_q    <= pc_in;
      imem_en <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
    end else begin
      if (do_issue) begin
        imem_addr <= pc_q;
        imem_en   <= 1'b1;
      end
      if (do_push) begin
        fifo_mem[wr_ptr] <= {pc_q, imem_rdata};
        wr_ptr           <= ~wr_ptr;
        pc_q             <= pc_q + 32'd4;
        imem_en          <= 1'b0;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign instr_pc    = fifo_mem[rd_ptr][63:32];
  assign instr_out   = fifo_mem[rd_ptr][31:0];
  assign instr_valid = (count_q != 2'd0);
  assign stall       = (({1'b0, count_q}) + {2'b00, (state_q == BUSY)}) == 3'd2;

`ifdef IMEM_FETCH_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (do_push && !pc_load) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_clk = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        out_ready = 1'b0;
  logic        stall;
`ifdef IMEM_FETCH_CNT_EN
  logic [15:0] fetch_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        imem_run = 1'b0;
  int          phase    = 0;

  logic [31:0] pop_pc   [16];
  logic [31:0] pop_data [16];
  int          pop_cyc  [16];
  int          pop_n;
  int          en_rises;
  logic        en_prev;
  logic        stall_seen;

  imem_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .imem_clk    (imem_clk),
    .pc_load     (pc_load),
    .pc_in       (pc_in),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .out_ready   (out_ready),
    .stall       (stall)
`ifdef IMEM_FETCH_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  // Memory model: data is a fixed function of the address.
  assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divided imem clock: 3 clk high, 3 clk low, changing 2 ns after a clk edge.
  always @(posedge clk) begin
    #2;
    if (!imem_run) begin
      phase    = 0;
      imem_clk = 1'b0;
    end else begin
      imem_clk = (phase < 3);
      phase    = (phase == 5) ? 0 : phase + 1;
    end
  end

  task automatic clear_mon();
    pop_n      = 0;
    en_rises   = 0;
    en_prev    = 1'b0;
    stall_seen = 1'b0;
  endtask

  // Records a pop that the coming rising edge will perform, then advances to the next negedge.
  task automatic tick();
    if (instr_valid && out_ready && pop_n < 16) begin
      pop_pc[pop_n]   = instr_pc;
      pop_data[pop_n] = instr_out;
      pop_cyc[pop_n]  = cyc;
      pop_n++;
    end
    if (imem_en && !en_prev) en_rises++;
    en_prev = imem_en;
    if (stall) stall_seen = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    imem_run  = 1'b0;
    pc_load   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic collect_until(input int n, input int budget);
    for (int i = 0; i < budget && pop_n < n; i++) tick();
  endtask

  task automatic wait_fetch(input logic [31:0] addr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (imem_en && imem_addr == addr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr_out: got %h expected 0", instr_out); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    do_reset();
    out_ready = 1'b1;
    imem_run  = 1'b1;
    collect_until(4, 200);
    n_checks++; if (pop_n !== 4) begin n_fail++; $display("FAIL stream_count: got %0d expected 4", pop_n); end
    for (int i = 0; i < 4 && i < pop_n; i++) begin
      n_checks++; if (pop_pc[i] !== exp_pc[i]) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pop_pc[i], exp_pc[i]); end
      n_checks++; if (pop_data[i] !== (exp_pc[i] ^ 32'hA5A5_A5A5)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, pop_data[i], exp_pc[i] ^ 32'hA5A5_A5A5); end
    end
    for (int i = 1; i < 4 && i < pop_n; i++) begin
      n_checks++; if (pop_cyc[i] - pop_cyc[i-1] !== 6) begin n_fail++; $display("FAIL stream_spacing[%0d]: got %0d expected 6", i, pop_cyc[i] - pop_cyc[i-1]); end
    end
    n_checks++; if (stall_seen !== 1'b0) begin n_fail++; $display("FAIL stream_stall: got %b expected 0", stall_seen); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    out_ready = 1'b0;
    imem_run  = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    n_checks++; if (en_rises !== 2) begin n_fail++; $display("FAIL bp_fetches: got %0d expected 2", en_rises); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall: got %b expected 1", stall); end
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL bp_no_third_fetch: got %b expected 0", imem_en); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h expected 0", instr_pc); end
    n_checks++; if (instr_out !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bp_head_data: got %h expected a5a5a5a5", instr_out); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL bp_head_after_pop: got %h expected 4", instr_pc); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL bp_stall_after_pop: got %b expected 0", stall); end
    wait_fetch(32'h8, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_resume_fetch8: got %b expected 1", ok); end
    out_ready = 1'b1;
    collect_until(3, 60);
    n_checks++; if (pop_n !== 3) begin n_fail++; $display("FAIL bp_pop_count: got %0d expected 3", pop_n); end
    n_checks++; if (pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) begin n_fail++; $display("FAIL bp_pop_order: got %h,%h expected 4,8", pop_pc[1], pop_pc[2]); end
  endtask

  task automatic test_redirect();
    bit ok;
    int n8;
    do_reset();
    out_ready = 1'b1;
    imem_run  = 1'b1;
    wait_fetch(32'h8, 100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL redir_reach_fetch8: got %b expected 1", ok); end
    pc_load = 1'b1;
    pc_in   = 32'h100;
    tick();
    pc_load = 1'b0;
    n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL redir_en_drop: got %b expected 0", imem_en); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", instr_valid); end
    wait_fetch(32'h100, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL redir_next_addr: got %h expected 100", imem_addr); end
    collect_until(5, 100);
    n_checks++; if (pop_n !== 5) begin n_fail++; $display("FAIL redir_pop_count: got %0d expected 5", pop_n); end
    n_checks++; if (pop_pc[2] !== 32'h100 || pop_pc[3] !== 32'h104 || pop_pc[4] !== 32'h108) begin n_fail++; $display("FAIL redir_seq: got %h,%h,%h expected 100,104,108", pop_pc[2], pop_pc[3], pop_pc[4]); end
    n8 = 0;
    for (int i = 0; i < pop_n; i++) if (pop_pc[i] == 32'h8) n8++;
    n_checks++; if (n8 !== 0) begin n_fail++; $display("FAIL redir_pc8_output: got %0d expected 0", n8); end
  endtask

  task automatic test_fall_collision();
    bit ok;
    logic prev;
    do_reset();
    out_ready = 1'b1;
    imem_run  = 1'b1;
    wait_fetch(32'h4, 100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coll_reach_fetch4: got %b expected 1", ok); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev = imem_clk;
      tick();
      if (prev && !imem_clk) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coll_fall_seen: got %b expected 1", ok); end
    tick();
    pc_load = 1'b1;
    pc_in   = 32'h200;
    tick();
    pc_load = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL coll_no_push: got %b expected 0", instr_valid); end
    collect_until(2, 60);
    n_checks++; if (pop_n !== 2 || pop_pc[1] !== 32'h200) begin n_fail++; $display("FAIL coll_next_pc: got %h (n=%0d) expected 200", pop_pc[1], pop_n); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    pc_load   = 1'b1;
    pc_in     = 32'hFFFF_FFFC;
    tick();
    pc_load  = 1'b0;
    imem_run = 1'b1;
    collect_until(2, 60);
    n_checks++; if (pop_n !== 2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", pop_n); end
    n_checks++; if (pop_pc[0] !== 32'hFFFF_FFFC || pop_data[0] !== 32'h5A5A_5A59) begin n_fail++; $display("FAIL wrap_first: got %h/%h expected fffffffc/5a5a5a59", pop_pc[0], pop_data[0]); end
    n_checks++; if (pop_pc[1] !== 32'h0 || pop_data[1] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL wrap_second: got %h/%h expected 0/a5a5a5a5", pop_pc[1], pop_data[1]); end
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    do_reset();
    out_ready = 1'b0;
    imem_run  = 1'b1;
    wait_fetch(32'h4, 100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_fetch4: got %b expected 1", ok); end
    reset = 1'b0;
    #1;
    n_checks++; if (imem_en !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_fetch_outputs: got en=%b addr=%h expected 0/0", imem_en, imem_addr); end
    n_checks++; if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr_out !== 32'h0) begin n_fail++; $display("FAIL rmid_buffer_outputs: got v=%b pc=%h d=%h expected 0", instr_valid, instr_pc, instr_out); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b expected 0", stall); end
`ifdef IMEM_FETCH_CNT_EN
    n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL rmid_count_reset: got %0d expected 0", fetch_count); end
`endif
    imem_run = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mon();
    out_ready = 1'b1;
    imem_run  = 1'b1;
    collect_until(3, 100);
    n_checks++; if (pop_n !== 3 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) begin n_fail++; $display("FAIL rmid_restart_seq: got n=%0d %h,%h,%h expected 0,4,8", pop_n, pop_pc[0], pop_pc[1], pop_pc[2]); end
`ifdef IMEM_FETCH_CNT_EN
    n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL rmid_count: got %0d expected 3", fetch_count); end
`endif
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fall_collision();
    test_wrap();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
